// File: rtl/k_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : k_alu_seq_if
// Brief   : Request/response bundle between the EX-stage controller and k_alu_seq.
// Rev     : 1.0
// ============================================================================
interface k_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] res;
  logic             busy;
  logic             done;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             dz;

  modport master (
    output start, sel, A, B,
    input  res, busy, done, zero, carry, ovf, dz
  );

  modport slave (
    input  start, sel, A, B,
    output res, busy, done, zero, carry, ovf, dz
  );
endinterface
`default_nettype wire

// File: rtl/k_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : k_alu_seq
// Brief   : Sequential ALU with start/done handshake and registered flags;
//           macro K_ALU_MULDIV_EN builds iterative MUL/MULHU/DIVU/REMU.
// Rev     : 1.0
// ============================================================================
module k_alu_seq #(
  parameter int WIDTH = 32
) (
  input wire         clk,
  input wire         rst,
  k_alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] c_ADD   = 4'b0000;
  localparam logic [3:0] c_SUB   = 4'b0001;
  localparam logic [3:0] c_AND   = 4'b0010;
  localparam logic [3:0] c_OR    = 4'b0011;
  localparam logic [3:0] c_XOR   = 4'b0100;
  localparam logic [3:0] c_NOR   = 4'b0101;
  localparam logic [3:0] c_SLL   = 4'b0110;
  localparam logic [3:0] c_SRL   = 4'b0111;
  localparam logic [3:0] c_SRA   = 4'b1000;
  localparam logic [3:0] c_SLT   = 4'b1001;
  localparam logic [3:0] c_SLTU  = 4'b1010;
  localparam logic [3:0] c_MUL   = 4'b1011;
  localparam logic [3:0] c_MULHU = 4'b1100;
  localparam logic [3:0] c_DIVU  = 4'b1101;
  localparam logic [3:0] c_REMU  = 4'b1110;
  localparam logic [3:0] c_PASSB = 4'b1111;

`ifdef K_ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIN = 2'd1, S_MUL = 2'd2, S_DIV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIN = 2'd1} state_t;
`endif

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic             r_dz;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic             w_alu_dz;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_sh;
  logic             w_accept;
  logic             w_multi;

  assign w_accept = bus.start && (r_state == S_IDLE);
  assign w_sh     = bus.B[SHW-1:0];
  assign w_sum    = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff   = {1'b0, bus.A} - {1'b0, bus.B};

  // Single-cycle result; bit WIDTH of w_diff is the borrow.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_dz  = 1'b0;
    case (bus.sel)
      c_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      c_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = ~w_diff[WIDTH];
        w_alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      c_AND:   w_alu_res = bus.A & bus.B;
      c_OR:    w_alu_res = bus.A | bus.B;
      c_XOR:   w_alu_res = bus.A ^ bus.B;
      c_NOR:   w_alu_res = ~(bus.A | bus.B);
      c_SLL:   w_alu_res = bus.A << w_sh;
      c_SRL:   w_alu_res = bus.A >> w_sh;
      c_SRA:   w_alu_res = $signed(bus.A) >>> w_sh;
      c_SLT:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      c_SLTU:  w_alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
`ifdef K_ALU_MULDIV_EN
      c_DIVU: begin
        w_alu_res = '1;
        w_alu_dz  = 1'b1;
      end
      c_REMU: begin
        w_alu_res = bus.A;
        w_alu_dz  = 1'b1;
      end
`endif
      c_PASSB: w_alu_res = bus.B;
      default: w_alu_res = '0;
    endcase
  end

`ifdef K_ALU_MULDIV_EN
  logic [3:0]         r_sel;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_quo;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     r_rem;

  logic [WIDTH:0]     w_psum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_md_res;
  logic               w_fits;
  logic               w_last;
  logic               w_is_mul;

  assign w_is_mul   = (bus.sel == c_MUL) || (bus.sel == c_MULHU);
  assign w_multi    = w_is_mul || (((bus.sel == c_DIVU) || (bus.sel == c_REMU)) && (bus.B != '0));
  assign w_last     = (r_cnt == SHW'(WIDTH - 1));

  // Shift-add: multiplier B sits in the low half and is consumed LSB first.
  assign w_psum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                      (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_prod_nxt = {w_psum, r_prod[WIDTH-1:1]};

  // Restoring divide: dividend bits enter the remainder from the quotient MSB.
  assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_opnd};
  assign w_fits     = r_rem[WIDTH] | ~w_trial[WIDTH];
  assign w_rem_nxt  = w_fits ? w_trial : w_shift;
  assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_fits};

  always_comb begin
    case (r_sel)
      c_MULHU: w_md_res = w_prod_nxt[2*WIDTH-1:WIDTH];
      c_DIVU:  w_md_res = w_quo_nxt;
      c_REMU:  w_md_res = w_rem_nxt[WIDTH-1:0];
      default: w_md_res = w_prod_nxt[WIDTH-1:0];
    endcase
  end
`else
  assign w_multi = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
`ifdef K_ALU_MULDIV_EN
          if (w_is_mul) begin
            w_next = S_MUL;
          end else if (w_multi) begin
            w_next = S_DIV;
          end else begin
            w_next = S_FIN;
          end
`else
          w_next = S_FIN;
`endif
        end
      end
`ifdef K_ALU_MULDIV_EN
      S_MUL: if (w_last) w_next = S_FIN;
      S_DIV: if (w_last) w_next = S_FIN;
`endif
      S_FIN: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
`ifdef K_ALU_MULDIV_EN
      r_sel   <= '0;
      r_cnt   <= '0;
      r_opnd  <= '0;
      r_quo   <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
`endif
    end else begin
      if (w_accept && !w_multi) begin
        r_res   <= w_alu_res;
        r_zero  <= (w_alu_res == '0);
        r_carry <= w_alu_c;
        r_ovf   <= w_alu_v;
        r_dz    <= w_alu_dz;
      end
`ifdef K_ALU_MULDIV_EN
      if (w_accept) begin
        r_sel  <= bus.sel;
        r_cnt  <= '0;
        r_opnd <= w_is_mul ? bus.A : bus.B;
        r_prod <= {{WIDTH{1'b0}}, bus.B};
        r_rem  <= '0;
        r_quo  <= bus.A;
      end
      if (r_state == S_MUL) begin
        r_prod <= w_prod_nxt;
      end
      if (r_state == S_DIV) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end
      if ((r_state == S_MUL) || (r_state == S_DIV)) begin
        r_cnt <= r_cnt + SHW'(1);
        if (w_last) begin
          r_res   <= w_md_res;
          r_zero  <= (w_md_res == '0);
          r_carry <= 1'b0;
          r_ovf   <= 1'b0;
          r_dz    <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.res   = r_res;
  assign bus.zero  = r_zero;
  assign bus.carry = r_carry;
  assign bus.ovf   = r_ovf;
  assign bus.dz    = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_k_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_k_alu_seq
// Brief   : Self-checking bench for k_alu_seq against an arithmetic reference model.
// Rev     : 1.0
// ============================================================================
module tb_k_alu_seq;
  localparam int W = 32;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SRA = 4'd8, MUL = 4'd11,
                         MULHU = 4'd12, DIVU = 4'd13, REMU = 4'd14;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  k_alu_seq_if #(.WIDTH(W)) ifc ();
  k_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                                output bit [31:0] r, output bit c, output bit v,
                                output bit d, output int lat);
    longint    sa = longint'($signed(a));
    longint    sb = longint'($signed(b));
    bit [63:0] ua = {32'd0, a};
    bit [63:0] ub = {32'd0, b};
    bit [63:0] t;
    r = 32'd0; c = 1'b0; v = 1'b0; d = 1'b0; lat = 1;
    case (op)
      4'd0: begin t = ua + ub; r = t[31:0]; c = t[32]; v = (sa + sb) != longint'($signed(r)); end
      4'd1: begin t = ua - ub; r = t[31:0]; c = (a >= b); v = (sa - sb) != longint'($signed(r)); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: r = 32'(ua << b[4:0]);
      4'd7: r = 32'(ua >> b[4:0]);
      4'd8: r = 32'(sa >>> b[4:0]);
      4'd9: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
`ifdef K_ALU_MULDIV_EN
      4'd11: begin t = ua * ub; r = t[31:0]; lat = W + 1; end
      4'd12: begin t = ua * ub; r = t[63:32]; lat = W + 1; end
      4'd13: if (b == 0) begin r = 32'hFFFF_FFFF; d = 1'b1; end else begin r = a / b; lat = W + 1; end
      4'd14: if (b == 0) begin r = a; d = 1'b1; end else begin r = a % b; lat = W + 1; end
`endif
      4'd15: r = b;
      default: r = 32'd0;
    endcase
  endfunction

  // Drives one request in the current cycle, then checks latency, result and flags.
  task automatic do_op(input string tag, input bit [3:0] op, input bit [31:0] a, input bit [31:0] b);
    bit [31:0] er;
    bit        ec, ev, ed, seen;
    int        elat, k;
    model(op, a, b, er, ec, ev, ed, elat);
    ifc.start = 1'b1; ifc.sel = op; ifc.A = a; ifc.B = b;
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.sel = 4'($urandom); ifc.A = $urandom; ifc.B = $urandom;
    seen = 1'b0; k = 0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) chk({tag, "_busy"}, 64'(ifc.busy), 64'd1);
      seen = ifc.done;
    end
    chk({tag, "_lat"}, 64'(k), 64'(elat));
    chk({tag, "_res"}, 64'(ifc.res), 64'(er));
    chk({tag, "_zero"}, 64'(ifc.zero), 64'(er == 32'd0));
    chk({tag, "_carry"}, 64'(ifc.carry), 64'(ec));
    chk({tag, "_ovf"}, 64'(ifc.ovf), 64'(ev));
    chk({tag, "_dz"}, 64'(ifc.dz), 64'(ed));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'({ifc.done, ifc.busy}), 64'd0);
    chk({tag, "_hold"}, 64'(ifc.res), 64'(er));
  endtask

  initial begin
    bit [31:0] ra, rb;
    bit [3:0]  rop;
    rst = 1'b1; ifc.start = 1'b0; ifc.sel = 4'd0; ifc.A = '0; ifc.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res", 64'(ifc.res), 64'd0);
    chk("rst_busy_done", 64'({ifc.busy, ifc.done}), 64'd0);
    chk("rst_flags", 64'({ifc.zero, ifc.carry, ifc.ovf, ifc.dz}), 64'd0);
    rst = 1'b0;

    do_op("add_8_3", ADD, 32'd8, 32'd3);
    chk("add_8_3_lit", 64'(ifc.res), 64'd11);
    do_op("add_ovf", ADD, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf_lit", 64'({ifc.ovf, ifc.res}), 64'h1_8000_0000);
    do_op("sub_eq", SUB, 32'd3, 32'd3);
    chk("sub_eq_lit", 64'({ifc.zero, ifc.carry}), 64'd3);
    do_op("sra", SRA, 32'h8000_0000, 32'd4);
    chk("sra_lit", 64'(ifc.res), 64'hF800_0000);
    do_op("mul", MUL, 32'h1_0000, 32'h3_0000);
    do_op("mulhu", MULHU, 32'h1_0000, 32'h3_0000);
    do_op("mul_5_6", MUL, 32'd5, 32'd6);
    do_op("divu", DIVU, 32'd100, 32'd7);
    do_op("remu", REMU, 32'd100, 32'd7);
    do_op("divu_z", DIVU, 32'd100, 32'd0);
`ifdef K_ALU_MULDIV_EN
    chk("divu_z_lit", 64'({ifc.dz, ifc.res}), 64'h1_FFFF_FFFF);
    begin : ignore_start
      bit seen;
      int lat;
      ifc.start = 1'b1; ifc.sel = MUL; ifc.A = 32'h1_0000; ifc.B = 32'h3_0000;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      seen = 1'b0; lat = 0;
      for (int k = 1; k <= 60 && !seen; k++) begin
        if (k == 5) begin ifc.start = 1'b1; ifc.sel = ADD; ifc.A = 32'd1; ifc.B = 32'd1; end
        @(negedge clk);
        if (ifc.done) begin seen = 1'b1; lat = k; end
        @(posedge clk); #1;
        ifc.start = 1'b0;
      end
      chk("ign_lat", 64'(lat), 64'(W + 1));
      chk("ign_res", 64'(ifc.res), 64'd0);
      chk("ign_idle", 64'(ifc.busy), 64'd0);
    end
    do_op("mulhu2", MULHU, 32'h1_0000, 32'h3_0000);
    chk("mulhu_lit", 64'(ifc.res), 64'd3);
    begin : mid_reset
      bit seen;
      ifc.start = 1'b1; ifc.sel = MUL; ifc.A = 32'h1234_5678; ifc.B = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        if (k == 10) rst = 1'b1;
        @(negedge clk);
        if (ifc.done) seen = 1'b1;
        @(posedge clk); #1;
      end
      rst = 1'b0;
      chk("mrst_nodone", 64'(seen), 64'd0);
      chk("mrst_busy_done", 64'({ifc.busy, ifc.done}), 64'd0);
      chk("mrst_res", 64'(ifc.res), 64'd0);
      chk("mrst_zero", 64'(ifc.zero), 64'd0);
    end
    do_op("after_rst", ADD, 32'd8, 32'd3);
`else
    chk("divu_z_lit", 64'({ifc.dz, ifc.res}), 64'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 40));
        2:       rb = $urandom;
        default: rb = ra;
      endcase
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/k_alu_seq.md
Name: k_alu_seq

Overview:
- Parametrised sequential ALU. Next generation of the 32-bit combinational K_ALU_32.
- Adds a start/done handshake, registered result and status flags.
- Adds multi-cycle unsigned multiply (shift-add) and divide (restoring).
- Sits in the EX stage of the datapath. The controller stalls while busy is high.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only when busy=0
- sel  in  4  opcode, sampled on accepted start
- A  in  WIDTH  operand A, sampled on accepted start
- B  in  WIDTH  operand B, sampled on accepted start
- res  out  WIDTH  registered result, held until the next done
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; res and flags valid
- zero  out  1  res==0
- carry  out  1  carry-out (ADD) / NOT borrow (SUB); 0 for all other ops
- ovf  out  1  signed overflow (ADD/SUB); 0 otherwise
- dz  out  1  divide-by-zero on DIVU/REMU; 0 otherwise

Behaviour:
- Reset: on the clk edge with rst=1, the FSM goes to IDLE and res, busy, done, zero, carry, ovf, dz all become 0. Reset mid-operation aborts; no done is produced.
- Opcodes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
  - 0110 SLL by B[SHW-1:0]; 0111 SRL; 1000 SRA.
  - 1001 SLT (signed, result 0/1); 1010 SLTU (unsigned, 0/1).
  - 1011 MUL (low WIDTH bits of A*B); 1100 MULHU (high WIDTH bits, unsigned).
  - 1101 DIVU (quotient); 1110 REMU (remainder); 1111 PASSB.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE: start=1 with a single-cycle op -> compute, register res/flags, go to FIN.
  - IDLE: start=1 with 1011/1100 -> MUL. With 1101/1110 -> DIV, or FIN if B==0.
  - MUL/DIV: one iteration per cycle, iteration counter 0..WIDTH-1. After iteration WIDTH-1 -> FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in MUL, DIV and FIN. busy=0 in IDLE.
- Latency, start accepted at edge N:
  - Single-cycle op or div-by-zero: done high in cycle N+1.
  - MUL/DIV: done high in cycle N+WIDTH+1.
  - Back-to-back: start is accepted on the cycle after done.
- start while busy=1 is ignored; operands and opcode are not re-sampled.
- Internal accumulators: MUL uses a 2*WIDTH product register. DIV keeps a WIDTH+1 partial remainder plus the quotient.
- Divide by zero: quotient = all ones, remainder = A, dz=1.
- zero is computed from the final res for every op.
- res and flags hold their values between done pulses. The flags are updated only at done.

Optional Feature:
- Macro: K_ALU_MULDIV_EN.
- Defined: MUL/MULHU/DIVU/REMU behave as above.
- Undefined:
  - The multiplier/divider datapath and the MUL/DIV states are not built.
  - Opcodes 1011..1110 complete as single-cycle ops with res=0, dz=0, done at N+1.
  - All other opcodes are unchanged.

Test Plan:
- WIDTH=32, A=8, B=3, sel=0000, start pulse -> done at N+1, res=11, zero=0, carry=0, ovf=0.
- A=32'h7FFFFFFF, B=1, ADD -> res=32'h80000000, ovf=1. Then SUB with A=3, B=3 -> res=0, zero=1, carry=1.
- MUL with A=32'h10000, B=32'h30000 -> busy for 33 cycles, done at N+33, res=0. Then MULHU with the same operands -> res=3.
- DIVU with A=100, B=7 -> done at N+33, res=14. REMU -> res=2. DIVU with B=0 -> done at N+1, res=32'hFFFFFFFF, dz=1.
- During MUL, at cycle N+5, pulse start with sel=0000 -> ignored, MUL result unchanged. Assert rst at N+10 -> busy=0, res=0, no done. A start at N+11 is accepted normally.
- Without K_ALU_MULDIV_EN: MUL with A=5, B=6 -> done at N+1, res=0. SRA with A=32'h80000000, B=4 -> res=32'hF8000000.
